// File: rtl/window_gen.sv
// Streaming 3x3 window generator: buffers the two previous rows of a
// raster pixel stream and presents each complete 3x3 neighbourhood with
// a one-cycle valid strobe, plus an end-of-frame pulse on the last window.
module window_gen #(
   parameter int unsigned IMG_WIDTH  = 160,
   parameter int unsigned IMG_HEIGHT = 120,
   parameter int unsigned PIX_W      = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [PIX_W-1:0]             pixelIn,
   input  logic                         pixelInValid,
   input  logic                         frameStart,
   output logic [2:0][2:0][PIX_W-1:0]   pixelData,
   output logic                         windowValid,
   output logic                         frameDone
);

   localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   logic [COL_W-1:0]            r_col;
   logic [ROW_W-1:0]            r_row;
   logic [PIX_W-1:0]            r_lb0 [IMG_WIDTH];
   logic [PIX_W-1:0]            r_lb1 [IMG_WIDTH];
   logic [2:0][2:0][PIX_W-1:0]  r_window;
   logic                        r_valid;
   logic                        r_done;

   logic [COL_W-1:0]            w_col;
   logic [ROW_W-1:0]            w_row;
   logic [PIX_W-1:0]            w_lb0_rd;
   logic [PIX_W-1:0]            w_lb1_rd;
   logic                        w_last_col;
   logic                        w_last_row;

   // Position of the pixel being accepted; frameStart forces it to (0,0)
   always_comb begin
      w_col = r_col;
      w_row = r_row;
      if (frameStart) begin
         w_col = '0;
         w_row = '0;
      end
   end

   assign w_last_col = (w_col == COL_W'(IMG_WIDTH - 1));
   assign w_last_row = (w_row == ROW_W'(IMG_HEIGHT - 1));

   // Combinational line-buffer read of the old values at this column
   assign w_lb0_rd = r_lb0[w_col];
   assign w_lb1_rd = r_lb1[w_col];

   // Line buffers: age row r-1 into the r-2 slot, then store the new pixel
   always_ff @(posedge clk) begin
      if (pixelInValid) begin
         r_lb0[w_col] <= w_lb1_rd;
         r_lb1[w_col] <= pixelIn;
      end
   end

   // Raster counters, window shift register and output strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_col    <= '0;
         r_row    <= '0;
         r_window <= '0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_valid <= pixelInValid && (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
         r_done  <= pixelInValid && w_last_row && w_last_col;
         if (pixelInValid) begin
            for (int r = 0; r < 3; r++) begin
               r_window[r][0] <= r_window[r][1];
               r_window[r][1] <= r_window[r][2];
            end
            r_window[0][2] <= w_lb0_rd;
            r_window[1][2] <= w_lb1_rd;
            r_window[2][2] <= pixelIn;
            if (w_last_col) begin
               r_col <= '0;
               r_row <= w_last_row ? '0 : w_row + ROW_W'(1);
            end else begin
               r_col <= w_col + COL_W'(1);
               r_row <= w_row;
            end
         end
      end
   end

   assign pixelData   = r_window;
   assign windowValid = r_valid;
   assign frameDone   = r_done;

endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen: a 4x4 instance for the small-frame corner cases and
// a default 160x120 instance for the full-frame run, both checked against a
// frame-image reference model.
module tb_window_gen;

   logic clk;
   logic reset;

   logic [3:0]            s_pix, b_pix;
   logic                  s_v, b_v, s_fs, b_fs;
   logic [2:0][2:0][3:0]  s_pd, b_pd;
   logic                  s_wv, b_wv, s_fd, b_fd;

   window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(4)) u_small (
      .clk(clk), .reset(reset), .pixelIn(s_pix), .pixelInValid(s_v),
      .frameStart(s_fs), .pixelData(s_pd), .windowValid(s_wv), .frameDone(s_fd)
   );

   window_gen u_big (
      .clk(clk), .reset(reset), .pixelIn(b_pix), .pixelInValid(b_v),
      .frameStart(b_fs), .pixelData(b_pd), .windowValid(b_wv), .frameDone(b_fd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] pix;
      bit         fs;
      bit         wv;
      bit         fd;
      int         tl;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;
   int n_wv  = 0;
   int n_fd  = 0;

   // Reference model: the current frame's image plus raster position
   logic [3:0] img [120][160];
   int         m_row, m_col;

   bit                    e_wv, e_fd;
   logic [2:0][2:0][3:0]  e_pd;
   bit                    a_wv, a_fd;
   logic [2:0][2:0][3:0]  a_pd;

   task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // One clock: drive selected DUT, compute model expectation, sample after edge
   task automatic step(input bit big, input bit v, input bit fs, input logic [3:0] p);
      int w, h, r, c;
      w = big ? 160 : 4;
      h = big ? 120 : 4;
      e_wv = 1'b0;
      e_fd = 1'b0;
      e_pd = '0;
      if (v) begin
         r = fs ? 0 : m_row;
         c = fs ? 0 : m_col;
         img[r][c] = p;
         e_wv = (r >= 2) && (c >= 2);
         e_fd = (r == h - 1) && (c == w - 1);
         if (e_wv)
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  e_pd[i][j] = img[r - 2 + i][c - 2 + j];
         if (c == w - 1) begin
            m_col = 0;
            m_row = (r == h - 1) ? 0 : r + 1;
         end else begin
            m_col = c + 1;
            m_row = r;
         end
      end
      s_v = 1'b0; s_fs = 1'b0; b_v = 1'b0; b_fs = 1'b0;
      if (big) begin
         b_v = v; b_fs = fs; b_pix = p;
      end else begin
         s_v = v; s_fs = fs; s_pix = p;
      end
      @(posedge clk);
      #1;
      a_wv = big ? b_wv : s_wv;
      a_fd = big ? b_fd : s_fd;
      a_pd = big ? b_pd : s_pd;
      if (a_wv) n_wv++;
      if (a_fd) n_fd++;
   endtask

   task automatic check_model(input string nm);
      check({nm, "_valid"}, 36'(a_wv), 36'(e_wv));
      check({nm, "_done"}, 36'(a_fd), 36'(e_fd));
      if (e_wv) check({nm, "_window"}, a_pd, e_pd);
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      for (int k = 0; k < cycles; k++) begin
         s_v = 1'($urandom_range(0, 1)); b_v = 1'($urandom_range(0, 1));
         s_fs = 1'($urandom_range(0, 1)); b_fs = 1'($urandom_range(0, 1));
         s_pix = 4'($urandom); b_pix = 4'($urandom);
         @(posedge clk);
         #1;
         check("reset_small", {s_pd, s_wv, s_fd} == '0 ? 36'd0 : 36'd1, 36'd0);
         check("reset_big", {b_pd, b_wv, b_fd} == '0 ? 36'd0 : 36'd1, 36'd0);
      end
      reset = 1'b0;
      s_v = 1'b0; b_v = 1'b0; s_fs = 1'b0; b_fs = 1'b0;
      m_row = 0;
      m_col = 0;
   endtask

   initial begin
      vec_t tbl [16];
      logic [2:0][2:0][3:0] t_pd;

      for (int k = 0; k < 16; k++) begin
         tbl[k].pix = 4'(k);
         tbl[k].fs  = (k == 0);
         tbl[k].wv  = 1'b0;
         tbl[k].fd  = 1'b0;
         tbl[k].tl  = 0;
      end
      tbl[10].wv = 1'b1; tbl[10].tl = 0;
      tbl[11].wv = 1'b1; tbl[11].tl = 1;
      tbl[14].wv = 1'b1; tbl[14].tl = 4;
      tbl[15].wv = 1'b1; tbl[15].tl = 5; tbl[15].fd = 1'b1;

      reset = 1'b1;
      s_v = 1'b0; b_v = 1'b0; s_fs = 1'b0; b_fs = 1'b0; s_pix = '0; b_pix = '0;
      m_row = 0; m_col = 0;

      // Test 1: reset with random inputs
      do_reset(3);

      // Test 2: 4x4 continuous frame from the constant table
      n_wv = 0; n_fd = 0;
      for (int k = 0; k < 16; k++) begin
         step(1'b0, 1'b1, tbl[k].fs, tbl[k].pix);
         check("t2_valid", 36'(a_wv), 36'(tbl[k].wv));
         check("t2_done", 36'(a_fd), 36'(tbl[k].fd));
         if (tbl[k].wv) begin
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  t_pd[i][j] = 4'(tbl[k].tl + 4 * i + j);
            check("t2_window", a_pd, t_pd);
         end
      end
      check("t2_windows", 36'(n_wv), 36'd4);
      check("t2_frames", 36'(n_fd), 36'd1);

      // Test 3: same stream with random gaps
      n_wv = 0; n_fd = 0;
      for (int k = 0; k < 16; k++) begin
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
            step(1'b0, 1'b0, 1'b0, 4'($urandom));
            check_model("t3_gap");
         end
         step(1'b0, 1'b1, (k == 0), 4'(k));
         check_model("t3");
      end
      check("t3_windows", 36'(n_wv), 36'd4);
      check("t3_frames", 36'(n_fd), 36'd1);

      // Test 4: frameStart reasserted at pixel (2,1) abandons the frame
      n_wv = 0; n_fd = 0;
      for (int k = 0; k < 9; k++) begin
         step(1'b0, 1'b1, (k == 0), 4'(k));
         check_model("t4_old");
      end
      check("t4_abandoned", 36'(n_wv + n_fd), 36'd0);
      for (int k = 9; k < 25; k++) begin
         step(1'b0, 1'b1, (k == 9), 4'(k));
         check_model("t4_new");
         if (k == 19) begin
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  t_pd[i][j] = 4'(9 + 4 * i + j);
            check("t4_first_window", a_pd, t_pd);
         end
      end
      check("t4_windows", 36'(n_wv), 36'd4);
      check("t4_frames", 36'(n_fd), 36'd1);

      // Test 5: two back-to-back frames, second without frameStart
      n_wv = 0; n_fd = 0;
      for (int k = 0; k < 32; k++) begin
         step(1'b0, 1'b1, (k == 0), 4'((k % 16) + (k / 16)));
         check_model("t5");
      end
      check("t5_windows", 36'(n_wv), 36'd8);
      check("t5_frames", 36'(n_fd), 36'd2);

      // Random stream with gaps and occasional frameStart, then reset mid-frame
      for (int k = 0; k < 400; k++) begin
         step(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), 4'($urandom));
         check_model("rand");
      end
      do_reset(2);
      n_wv = 0; n_fd = 0;
      for (int k = 0; k < 16; k++) begin
         step(1'b0, 1'b1, 1'b0, 4'($urandom));
         check_model("post_reset");
      end
      check("post_reset_windows", 36'(n_wv), 36'd4);
      check("post_reset_frames", 36'(n_fd), 36'd1);

      // Test 6: full default-size frame with random pixels and sparse gaps
      do_reset(1);
      n_wv = 0; n_fd = 0;
      for (int k = 0; k < 160 * 120; k++) begin
         if ($urandom_range(0, 15) == 0) begin
            step(1'b1, 1'b0, 1'b0, 4'($urandom));
            check_model("t6_gap");
         end
         step(1'b1, 1'b1, (k == 0), 4'($urandom));
         check_model("t6");
      end
      check("t6_windows", 36'(n_wv), 36'd18644);
      check("t6_frames", 36'(n_fd), 36'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/window_gen.md
Name: window_gen

Overview:
- Streaming 3x3 window generator; the producer that feeds the edge detector's 3x3 pixelData / inputValid interface.
- Accepts a raster-order (row-major) stream of 4-bit grayscale pixels and buffers the two previous image rows in line buffers.
- For every pixel that completes a full 3x3 neighbourhood, presents that neighbourhood with a one-cycle valid strobe.
- Sits between the camera/pixel ingest path and edgeDetect.

Parameters:
- IMG_WIDTH, 160, pixels per row (min 3)
- IMG_HEIGHT, 120, rows per frame (min 3)
- PIX_W, 4, bits per pixel

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- pixelIn  input  PIX_W  incoming pixel value
- pixelInValid  input  1  pixelIn is accepted this cycle; no backpressure
- frameStart  input  1  qualified by pixelInValid; marks the current pixel as (row 0, col 0)
- pixelData  output  PIX_W x [3][3]  window; [r][c] with r=0 the oldest row and c=0 the leftmost (oldest) column
- windowValid  output  1  pixelData holds a complete window this cycle (maps to edgeDetect inputValid)
- frameDone  output  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Interface:
  - One clock (clk); reset is synchronous and active-high.
  - No ready signal; an upstream pixel is consumed on every cycle pixelInValid=1.
- Reset:
  - col/row counters = 0.
  - pixelData all zero; windowValid = 0; frameDone = 0.
  - Line buffer contents are not cleared; they are don't-care.
- Counters:
  - col runs 0..IMG_WIDTH-1 and row runs 0..IMG_HEIGHT-1. Both advance only on an accepted pixel.
  - col wraps at IMG_WIDTH-1 and increments row.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to (0,0), so the next frame needs no frameStart.
- frameStart:
  - When frameStart=1 with pixelInValid=1, that pixel is processed as (0,0) regardless of counter state. Counters then advance to (0,1).
  - Abandoned partial frame: no frameDone.
  - frameStart while pixelInValid=0: ignored.
- Line buffers: two IMG_WIDTH x PIX_W arrays.
  - lb1 holds row r-1; lb0 holds row r-2.
  - On an accepted pixel at column c, lb1[c] and lb0[c] are read as old values, then written: lb0[c] <= lb1[c], lb1[c] <= pixelIn.
  - Read-before-write at the same address in the same cycle is required.
- Window update on an accepted pixel:
  - Columns shift left: pixelData[r][0] <= pixelData[r][1], pixelData[r][1] <= pixelData[r][2], for all r.
  - pixelData[0][2] <= lb0[c], pixelData[1][2] <= lb1[c], pixelData[2][2] <= pixelIn.
  - No accepted pixel: pixelData holds.
- Valid generation (registered):
  - windowValid <= pixelInValid && row>=2 && col>=2, using the counter values of the accepted pixel (post-frameStart override).
  - Latency: 1 cycle from accepting pixel (r,c) to windowValid. pixelData[2][2] = pixel(r,c); pixelData[0][0] = pixel(r-2,c-2).
  - Windows at col 0/1 mix the previous row's right edge; they are suppressed by the col>=2 term.
  - Rows 0/1 never validate, so stale line-buffer data is never exposed.
  - Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- frameDone:
  - frameDone <= accepted pixel is (IMG_HEIGHT-1, IMG_WIDTH-1).
  - Always coincides with a windowValid pulse.
- Gaps: pixelInValid may drop for any number of cycles mid-row or mid-frame. The output window sequence is identical to the gapless case; windowValid=0 during gaps.
- Reset mid-frame: takes effect at the next edge. Outputs go to 0, and the next accepted pixel is treated as (0,0).
- Storage: line buffers may be flops or distributed RAM. Combinational read is required; no extra pipeline stage is allowed.

Test Plan:
1. Reset held 3 cycles with random pixelIn/pixelInValid -> pixelData all 0, windowValid=0, frameDone=0 throughout.
2. IMG_WIDTH=4, IMG_HEIGHT=4, continuous stream with pixel(r,c)=r*4+c, frameStart on first -> exactly 4 windowValid pulses.
   - First pulse (after pixel (2,2)): rows {0,1,2},{4,5,6},{8,9,10}.
   - Last pulse: rows {5,6,7},{9,10,11},{13,14,15}, with frameDone=1 that cycle only.
3. Same stream as test 2 with random 0-3 cycle gaps in pixelInValid -> identical window sequence and frameDone; windowValid never asserted during gaps.
4. Same stream as test 2, frameStart reasserted at pixel (2,1) -> no frameDone for the abandoned frame; no windowValid until the new frame's (2,2), whose window holds the new frame's data.
5. Two back-to-back 4x4 frames (second uses values +1, no frameStart) -> 8 windows total, all from the correct frame, and two frameDone pulses.
6. Default 160x120 full frame vs. software reference -> 158*118 = 18644 windows, all matching.
